// File: rtl/bms_wd_kick_ctrl_if.sv
// Purpose : bundles the control inputs and status outputs of the BMS watchdog kick generator.
// Ports   : enable/task_alive/clear_fault toward the generator; kick, kick_fault, alive_seen,
//           miss_count and state back from it. master = stimulus side, slave = generator side.
interface bms_wd_kick_ctrl_if #(
  parameter int N_TASKS = 3
);
  logic               enable;
  logic [N_TASKS-1:0] task_alive;
  logic               clear_fault;
  logic               kick;
  logic               kick_fault;
  logic [N_TASKS-1:0] alive_seen;
  logic [3:0]         miss_count;
  logic [1:0]         state;

  modport master (
    output enable, task_alive, clear_fault,
    input  kick, kick_fault, alive_seen, miss_count, state
  );

  modport slave (
    input  enable, task_alive, clear_fault,
    output kick, kick_fault, alive_seen, miss_count, state
  );
endinterface

// File: rtl/bms_wd_kick_ctrl.sv
// Purpose : health-gated watchdog kick generator; kicks once per window only if every task
//           reported alive in that window, latches a fault after MAX_MISS missed windows.
// Latency : all outputs registered; kick appears the cycle after the window-end edge.
// Ports   : clk, rst_n (async active-low) plus the slave side of bms_wd_kick_ctrl_if.
module bms_wd_kick_ctrl #(
  parameter int          N_TASKS     = 3,
  parameter logic [23:0] KICK_PERIOD = 24'd1000000,
  parameter logic [3:0]  MAX_MISS    = 4'd3
) (
  input logic                clk,
  input logic                rst_n,
  bms_wd_kick_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COLLECT = 2'b01,
    FAULT   = 2'b10
  } state_t;

  state_t             state_q, state_d;
  logic [23:0]        cnt_q, cnt_d;
  logic [N_TASKS-1:0] seen_q, seen_d;
  logic [3:0]         miss_q, miss_d;
  logic               kick_q, kick_d;
  logic               fault_q, fault_d;

  // Heartbeats arriving in the closing cycle still count for that window.
  logic [N_TASKS-1:0] merged;
  logic               all_ok;
  logic               win_end;
  logic [3:0]         miss_inc;

  assign merged   = seen_q | bus.task_alive;
  assign all_ok   = &merged;
  assign win_end  = (cnt_q == KICK_PERIOD - 24'd1);
  assign miss_inc = (miss_q >= MAX_MISS) ? MAX_MISS : miss_q + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      seen_q  <= '0;
      miss_q  <= '0;
      kick_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seen_q  <= seen_d;
      miss_q  <= miss_d;
      kick_q  <= kick_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    seen_d  = seen_q;
    miss_d  = miss_q;
    kick_d  = 1'b0;
    fault_d = fault_q;

    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        seen_d  = '0;
        fault_d = 1'b0;
        if (bus.enable) begin
          // Initial kick on arming so the watchdog starts from a fresh timeout.
          state_d = COLLECT;
          kick_d  = 1'b1;
        end
      end

      COLLECT: begin
        if (!bus.enable) begin
          // Disarm wins over a coinciding window end: nothing is evaluated.
          state_d = IDLE;
          cnt_d   = '0;
          seen_d  = '0;
          miss_d  = '0;
        end else if (win_end) begin
          cnt_d  = '0;
          seen_d = '0;
          if (all_ok) begin
            kick_d = 1'b1;
            miss_d = '0;
          end else begin
            miss_d = miss_inc;
            if (miss_inc == MAX_MISS) begin
              state_d = FAULT;
              fault_d = 1'b1;
            end
          end
        end else begin
          cnt_d  = cnt_q + 24'd1;
          seen_d = merged;
        end
      end

      FAULT: begin
        // Kicks withheld until software clears the fault; enable is ignored here.
        cnt_d   = '0;
        seen_d  = '0;
        fault_d = 1'b1;
        if (bus.clear_fault) begin
          state_d = IDLE;
          miss_d  = '0;
          fault_d = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        seen_d  = '0;
        miss_d  = '0;
        fault_d = 1'b0;
      end
    endcase
  end

  assign bus.kick       = kick_q;
  assign bus.kick_fault = fault_q;
  assign bus.alive_seen = seen_q;
  assign bus.miss_count = miss_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_bms_wd_kick_ctrl.sv
// Purpose : randomized + directed bench for bms_wd_kick_ctrl with a queue-based scoreboard.
// Ports   : none; instantiates the interface and the generator with KICK_PERIOD=16, MAX_MISS=3.
module tb_bms_wd_kick_ctrl;

  localparam int N     = 3;
  localparam int KP    = 16;
  localparam int MAXM  = 3;

  typedef struct {
    int kick;
    int kick_fault;
    int seen;
    int miss;
    int st;
  } exp_t;

  logic clk;
  logic rst_n;

  bms_wd_kick_ctrl_if #(.N_TASKS(N)) bus ();

  bms_wd_kick_ctrl #(
    .N_TASKS    (N),
    .KICK_PERIOD(24'd16),
    .MAX_MISS   (4'd3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  exp_t sb_q[$];

  task automatic chk(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks what the generator is doing (off / watching a window / faulted), how many
  // cycles of the current window have elapsed, and which tasks have checked in.
  localparam int OFF = 0, WATCH = 1, FAULTED = 2;
  int m_mode   = OFF;
  int m_age    = 0;
  int m_seen   = 0;
  int m_misses = 0;

  always @(posedge clk) begin
    exp_t e;
    int   ta;
    int   kick_now;
    ta       = int'(bus.task_alive);
    kick_now = 0;
    if (!rst_n) begin
      m_mode = OFF; m_age = 0; m_seen = 0; m_misses = 0;
    end else begin
      case (m_mode)
        OFF: if (bus.enable) begin
          m_mode = WATCH; m_age = 0; m_seen = 0; kick_now = 1;
        end
        WATCH: begin
          if (!bus.enable) begin
            m_mode = OFF; m_age = 0; m_seen = 0; m_misses = 0;
          end else if (m_age == KP - 1) begin
            if ((m_seen | ta) == (1 << N) - 1) begin
              kick_now = 1;
              m_misses = 0;
            end else begin
              m_misses = (m_misses + 1 > MAXM) ? MAXM : m_misses + 1;
              if (m_misses == MAXM) m_mode = FAULTED;
            end
            m_age  = 0;
            m_seen = 0;
          end else begin
            m_age  = m_age + 1;
            m_seen = m_seen | ta;
          end
        end
        default: if (bus.clear_fault) begin
          m_mode = OFF; m_misses = 0;
        end
      endcase
    end
    e.kick       = kick_now;
    e.kick_fault = (m_mode == FAULTED) ? 1 : 0;
    e.seen       = m_seen;
    e.miss       = m_misses;
    e.st         = m_mode;
    sb_q.push_back(e);
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("kick",       int'(bus.kick),       e.kick);
      chk("kick_fault", int'(bus.kick_fault), e.kick_fault);
      chk("alive_seen", int'(bus.alive_seen), e.seen);
      chk("miss_count", int'(bus.miss_count), e.miss);
      chk("state",      int'(bus.state),      e.st);
    end
  end

  // ---------------- stimulus ----------------
  // Inputs set here are sampled by the DUT and the model at the next rising edge;
  // the task returns 1 time unit after that edge.
  task automatic step(input logic en, input logic [N-1:0] ta, input logic clr);
    bus.enable      = en;
    bus.task_alive  = ta;
    bus.clear_fault = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.enable      = 1'b0;
    bus.task_alive  = '0;
    bus.clear_fault = 1'b0;
    repeat (3) step(1'b0, '0, 1'b0);
    rst_n = 1'b1;
    repeat (2) step(1'b0, '0, 1'b0);

    // 1: arm with no heartbeats -> initial kick, three misses, fault, stays silent.
    repeat (1 + 3 * KP + 100) step(1'b1, '0, 1'b0);
    chk("t1_state_fault", int'(bus.state), 2);
    chk("t1_kick_fault", int'(bus.kick_fault), 1);

    // 5: clear with enable held -> IDLE, then COLLECT with initial kick.
    step(1'b1, '0, 1'b1);
    chk("t5_state_idle", int'(bus.state), 0);
    chk("t5_miss_zero", int'(bus.miss_count), 0);
    step(1'b1, '0, 1'b0);
    chk("t5_initial_kick", int'(bus.kick), 1);

    // 2: all tasks healthy, pulsed every 5 cycles.
    for (int i = 0; i < 5 * KP; i++)
      step(1'b1, (i % 5 == 0) ? 3'b111 : 3'b000, 1'b0);
    step(1'b0, '0, 1'b0);

    // 3: last-cycle pulse closes a window; first-cycle pulse opens the next.
    step(1'b1, '0, 1'b0);
    for (int i = 0; i < 2 * KP; i++) begin
      logic [N-1:0] ta;
      ta = '0;
      if (i < KP) begin
        if (m_age == 4)       ta = 3'b011;
        if (m_age == KP - 1)  ta = ta | 3'b100;
      end else begin
        if (m_age == 0)       ta = 3'b100;
        if (m_age == 6)       ta = 3'b011;
      end
      step(1'b1, ta, 1'b0);
    end
    step(1'b0, '0, 1'b0);

    // 4: good, miss, miss, good.
    step(1'b1, '0, 1'b0);
    for (int w = 0; w < 4; w++)
      for (int i = 0; i < KP; i++)
        step(1'b1, ((w == 0 || w == 3) && m_age == 3) ? 3'b111 : 3'b000, 1'b0);
    chk("t4_no_fault", int'(bus.kick_fault), 0);
    step(1'b0, '0, 1'b0);

    // Random traffic: sparse heartbeats, occasional disarm and clear.
    for (int i = 0; i < 2000; i++) begin
      logic [N-1:0] ta;
      logic         en;
      logic         clr;
      for (int b = 0; b < N; b++) ta[b] = ($urandom_range(0, 11) == 0);
      en  = ($urandom_range(0, 199) != 0);
      clr = ($urandom_range(0, 19) == 0);
      step(en, ta, clr);
    end
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);

    // 6: asynchronous reset mid-window at counter 9.
    step(1'b1, '0, 1'b0);
    for (int i = 0; i < KP && m_age != 9; i++)
      step(1'b1, (m_age == 2) ? 3'b111 : 3'b000, 1'b0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_async_kick",       int'(bus.kick),       0);
    chk("t6_async_kick_fault", int'(bus.kick_fault), 0);
    chk("t6_async_alive_seen", int'(bus.alive_seen), 0);
    chk("t6_async_miss",       int'(bus.miss_count), 0);
    chk("t6_async_state",      int'(bus.state),      0);
    @(posedge clk);
    #1;
    repeat (2) step(1'b0, 3'b111, 1'b0);
    rst_n = 1'b1;
    repeat (3) step(1'b0, 3'b111, 1'b0);
    chk("t6_idle_after_release", int'(bus.state), 0);
    step(1'b1, '0, 1'b0);
    chk("t6_rearm_kick", int'(bus.kick), 1);
    repeat (KP + 4) step(1'b1, 3'b111, 1'b0);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
